// File: rtl/msk_ref_pipe.sv
// msk_ref_pipe: pipelined d-share Boolean-masked refresh gadget with handshake.
// Optional second ring-mask layer (latency 3) enabled by MSK_REF_DOUBLE_RING_EN.
module msk_ref_pipe #(
    parameter int d     = 2,
    parameter int W     = 8,
    parameter int CNT_W = 16,
    localparam int NRB  = (d == 2) ? 1 : (d == 3) ? 2 : d,
`ifdef MSK_REF_DOUBLE_RING_EN
    localparam int NL   = 2,
`else
    localparam int NL   = 1,
`endif
    localparam int NR   = NRB * NL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [d*W-1:0]   in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W*NR-1:0]  rnd,
    input  logic             rnd_valid,
    output logic [d*W-1:0]   out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] ref_cnt
);

    generate
        if (d < 2 || d > 16) begin : g_bad_d
            $error("msk_ref_pipe: d must be in 2..16");
        end
    endgenerate

    // One mask layer: per bit, shares' masks XOR to zero.
    function automatic logic [d*W-1:0] mask_layer(
        input logic [W*NR-1:0] r,
        input int              l
    );
        logic [d*W-1:0] m;
        logic [15:0]    s;
        m = '0;
        for (int b = 0; b < W; b++) begin
            s = 16'(r[b*NR + l*NRB +: NRB]);
            for (int i = 0; i < d; i++) begin
                if (d == 2)
                    m[i*W+b] = s[0];
                else if (d == 3)
                    m[i*W+b] = (i == 2) ? (s[0] ^ s[1]) : s[i];
                else
                    m[i*W+b] = s[i] ^ s[(i+d-1)%d];
            end
        end
        return m;
    endfunction

    logic v1;
    logic v2;
    logic adv2;
    logic acc;

    // Input shares and masks kept apart so synthesis cannot merge shares.
    (* keep = "true" *) logic [d*W-1:0] data_s1;
    (* keep = "true" *) logic [d*W-1:0] mask_s1;
    logic [d*W-1:0] data_s2;
    logic [CNT_W-1:0] cnt;

`ifdef MSK_REF_DOUBLE_RING_EN
    logic v3;
    logic adv3;
    (* keep = "true" *) logic [d*W-1:0] mask2_s1;
    logic [d*W-1:0] mask2_s2;
    logic [d*W-1:0] data_s3;

    assign adv3      = !v3 | out_ready;
    assign adv2      = !v2 | adv3;
    assign out_valid = v3;
    assign out_data  = data_s3;
`else
    assign adv2      = !v2 | out_ready;
    assign out_valid = v2;
    assign out_data  = data_s2;
`endif

    assign in_ready = !v1 | adv2;
    assign acc      = in_valid & in_ready & rnd_valid;
    assign ref_cnt  = cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            data_s1  <= '0;
            mask_s1  <= '0;
            data_s2  <= '0;
            cnt      <= '0;
`ifdef MSK_REF_DOUBLE_RING_EN
            v3       <= 1'b0;
            mask2_s1 <= '0;
            mask2_s2 <= '0;
            data_s3  <= '0;
`endif
        end else begin
            if (in_ready) begin
                v1 <= acc;
                if (acc) begin
                    data_s1  <= in_data;
                    mask_s1  <= mask_layer(rnd, 0);
`ifdef MSK_REF_DOUBLE_RING_EN
                    mask2_s1 <= mask_layer(rnd, 1);
`endif
                end
            end
            if (adv2) begin
                v2 <= v1;
                if (v1) begin
                    data_s2  <= data_s1 ^ mask_s1;
`ifdef MSK_REF_DOUBLE_RING_EN
                    mask2_s2 <= mask2_s1;
`endif
                end
            end
`ifdef MSK_REF_DOUBLE_RING_EN
            if (adv3) begin
                v3 <= v2;
                if (v2)
                    data_s3 <= data_s2 ^ mask2_s2;
            end
`endif
            if (out_valid & out_ready)
                cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_msk_ref_pipe.sv
// tb_msk_ref_pipe: three msk_ref_pipe instances (d=3/4/2) checked against
// a word-level masking model with an in-order scoreboard.
module tb_msk_ref_pipe;

`ifdef MSK_REF_DOUBLE_RING_EN
    localparam int DBL = 2;
`else
    localparam int DBL = 1;
`endif
    localparam int LAT = 1 + DBL;
    localparam int DD[3] = '{3, 4, 2};
    localparam int WW[3] = '{4, 8, 8};
    localparam int CW[3] = '{4, 16, 16};
    localparam int NB[3] = '{2, 4, 1};
    localparam int RW0 = 4 * 2 * DBL;
    localparam int RW1 = 8 * 4 * DBL;
    localparam int RW2 = 8 * 1 * DBL;
    localparam int RWA[3] = '{RW0, RW1, RW2};

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [127:0] in_data [3];
    logic [255:0] rnd [3];
    logic         in_valid [3];
    logic         rnd_valid [3];
    logic         out_ready [3];

    logic         in_ready_a [3];
    logic         out_valid_a [3];
    logic [127:0] out_data_a [3];
    logic [15:0]  cnt_a [3];

    logic [11:0] dout0;
    logic [31:0] dout1;
    logic [15:0] dout2;
    logic [3:0]  cnt0;
    logic [15:0] cnt1;
    logic [15:0] cnt2;
    logic ir0, ir1, ir2, ov0, ov1, ov2;

    logic [127:0] qe [3][$];
    logic [15:0]  qx [3][$];
    int exp_cnt [3];
    int cmp = 0;
    int mism = 0;
    int cur_k = 0;
    int sent;
    bit a;

    always #5 clk = ~clk;

    assign out_data_a[0] = 128'(dout0);
    assign out_data_a[1] = 128'(dout1);
    assign out_data_a[2] = 128'(dout2);
    assign cnt_a[0] = 16'(cnt0);
    assign cnt_a[1] = cnt1;
    assign cnt_a[2] = cnt2;
    assign in_ready_a[0] = ir0;
    assign in_ready_a[1] = ir1;
    assign in_ready_a[2] = ir2;
    assign out_valid_a[0] = ov0;
    assign out_valid_a[1] = ov1;
    assign out_valid_a[2] = ov2;

    msk_ref_pipe #(.d(3), .W(4), .CNT_W(4)) u0 (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data[0][11:0]), .in_valid(in_valid[0]),
        .in_ready(ir0), .rnd(rnd[0][RW0-1:0]),
        .rnd_valid(rnd_valid[0]), .out_data(dout0),
        .out_valid(ov0), .out_ready(out_ready[0]), .ref_cnt(cnt0)
    );

    msk_ref_pipe #(.d(4), .W(8), .CNT_W(16)) u1 (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data[1][31:0]), .in_valid(in_valid[1]),
        .in_ready(ir1), .rnd(rnd[1][RW1-1:0]),
        .rnd_valid(rnd_valid[1]), .out_data(dout1),
        .out_valid(ov1), .out_ready(out_ready[1]), .ref_cnt(cnt1)
    );

    msk_ref_pipe #(.d(2), .W(8), .CNT_W(16)) u2 (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data[2][15:0]), .in_valid(in_valid[2]),
        .in_ready(ir2), .rnd(rnd[2][RW2-1:0]),
        .rnd_valid(rnd_valid[2]), .out_data(dout2),
        .out_valid(ov2), .out_ready(out_ready[2]), .ref_cnt(cnt2)
    );

    // Word-level model: gather random word j from bit j of each slice,
    // build each share's mask word from the per-d rule, XOR it in.
    function automatic logic [127:0] ref_out(int k, logic [127:0] din,
                                             logic [255:0] r);
        int dd = DD[k];
        int w  = WW[k];
        int nb = NB[k];
        int nr = NB[k] * DBL;
        logic [127:0] o = din;
        logic [15:0]  rw [16];
        logic [15:0]  m;
        for (int l = 0; l < DBL; l++) begin
            for (int j = 0; j < nb; j++) begin
                rw[j] = '0;
                for (int b = 0; b < w; b++)
                    rw[j][b] = r[b*nr + l*nb + j];
            end
            for (int i = 0; i < dd; i++) begin
                if (dd == 2)
                    m = rw[0];
                else if (dd == 3)
                    m = (i < 2) ? rw[i] : (rw[0] ^ rw[1]);
                else
                    m = rw[i] ^ rw[(i+dd-1)%dd];
                o = o ^ (128'(m & 16'((1 << w) - 1)) << (i*w));
            end
        end
        return o;
    endfunction

    function automatic logic [15:0] xr(int k, logic [127:0] v);
        logic [15:0] s = '0;
        for (int i = 0; i < DD[k]; i++)
            s = s ^ 16'((v >> (i*WW[k])) & ((128'b1 << WW[k]) - 1));
        return s;
    endfunction

    function automatic logic [255:0] rvec(int n);
        logic [255:0] v;
        v = {$urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, $urandom};
        if (n < 256)
            v = v & ((256'b1 << n) - 1);
        return v;
    endfunction

    task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
        cmp++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s k=%0d observed=%h expected=%h",
                   tag, cur_k, obs, exp);
        end
    endtask

    // One clock of instance k: sample at negedge, update the model, advance.
    task automatic step(int k, output bit acc);
        int n;
        @(negedge clk);
        cur_k = k;
        n = qe[k].size();
        check("in_ready", 128'(in_ready_a[k]),
              128'((n == LAT && !out_ready[k]) ? 0 : 1));
        if (out_valid_a[k] && out_ready[k]) begin
            if (n == 0) begin
                check("spurious_out", 128'(out_valid_a[k]), 128'(0));
            end else begin
                check("out_data", out_data_a[k], qe[k].pop_front());
                check("unmasked", 128'(xr(k, out_data_a[k])),
                      128'(qx[k].pop_front()));
                exp_cnt[k]++;
            end
        end
        acc = in_valid[k] && in_ready_a[k] && rnd_valid[k];
        if (acc) begin
            qe[k].push_back(ref_out(k, in_data[k], rnd[k]));
            qx[k].push_back(xr(k, in_data[k]));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(int k);
        cur_k = k;
        check("ref_cnt", 128'(cnt_a[k]),
              128'(exp_cnt[k] % (1 << CW[k])));
    endtask

    task automatic stream(int k, int nw, int pv, int pr);
        int guard = 0;
        bit ac;
        sent = 0;
        while ((sent < nw || qe[k].size() != 0) && guard < nw*20 + 50) begin
            in_valid[k]  = (sent < nw) && ($urandom_range(99) < pv);
            rnd_valid[k] = $urandom_range(99) < pv;
            out_ready[k] = $urandom_range(99) < pr;
            in_data[k]   = 128'(rvec(DD[k]*WW[k]));
            rnd[k]       = rvec(RWA[k]);
            step(k, ac);
            if (ac) sent++;
            guard++;
        end
        in_valid[k] = 1'b0;
        cur_k = k;
        check("stream_sent", 128'(sent), 128'(nw));
        check("stream_drain", 128'(qe[k].size()), 128'(0));
    endtask

    task automatic single(int k, logic [127:0] din, logic [255:0] r,
                          logic [127:0] exp);
        bit ac;
        in_data[k] = din;
        rnd[k] = r;
        in_valid[k] = 1'b1;
        rnd_valid[k] = 1'b1;
        out_ready[k] = 1'b1;
        step(k, ac);
        check("single_accept", 128'(ac), 128'(1));
        in_valid[k] = 1'b0;
        for (int c = 1; c < LAT; c++) begin
            check("single_early", 128'(out_valid_a[k]), 128'(0));
            step(k, ac);
        end
        check("single_valid", 128'(out_valid_a[k]), 128'(1));
        check("single_data", out_data_a[k], exp);
        step(k, ac);
        check_cnt(k);
    endtask

    task automatic do_reset(int edges);
        for (int k = 0; k < 3; k++) begin
            in_valid[k] = 1'b0;
            rnd_valid[k] = 1'b0;
            out_ready[k] = 1'b0;
            qe[k].delete();
            qx[k].delete();
            exp_cnt[k] = 0;
        end
        rst_n = 1'b0;
        repeat (edges) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cur_k = k;
            check("rst_out_valid", 128'(out_valid_a[k]), 128'(0));
            check("rst_out_data", out_data_a[k], 128'(0));
            check("rst_ref_cnt", 128'(cnt_a[k]), 128'(0));
            check("rst_in_ready", 128'(in_ready_a[k]), 128'(1));
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            in_data[k] = '0;
            rnd[k] = '0;
        end
        do_reset(3);

        // d=3 directed word: shares A,5,3 with all-ones randomness
        single(0, 128'h35A, {256{1'b1}},
               (DBL == 1) ? 128'h3A5 : 128'h35A);

        // d=4 ring masks cancel with all-ones randomness
        single(1, 128'hC3A5_0F96, {256{1'b1}}, 128'hC3A5_0F96);

        stream(1, 1000, 80, 70);
        check_cnt(1);
        stream(0, 200, 80, 70);
        check_cnt(0);
        stream(2, 200, 80, 70);
        check_cnt(2);

        // d=2: valid without fresh randomness is never accepted
        in_valid[2] = 1'b1;
        rnd_valid[2] = 1'b0;
        out_ready[2] = 1'b1;
        in_data[2] = 128'hBEEF;
        rnd[2] = 128'h5A;
        for (int c = 0; c < 5; c++) begin
            step(2, a);
            check("norand_out_valid", 128'(out_valid_a[2]), 128'(0));
        end
        rnd_valid[2] = 1'b1;
        step(2, a);
        check("rnd_accept", 128'(a), 128'(1));
        in_valid[2] = 1'b0;
        for (int c = 1; c < LAT; c++) begin
            check("rnd_early", 128'(out_valid_a[2]), 128'(0));
            step(2, a);
        end
        check("rnd_valid_out", 128'(out_valid_a[2]), 128'(1));
        step(2, a);

        // d=4 back-pressure: only LAT words fit while out_ready is low
        out_ready[1] = 1'b0;
        rnd_valid[1] = 1'b1;
        sent = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid[1] = sent < 3;
            in_data[1] = 128'(rvec(32));
            rnd[1] = rvec(RW1);
            step(1, a);
            if (a) sent++;
        end
        cur_k = 1;
        check("stall_accepted", 128'(sent), 128'(LAT));
        check("stall_in_ready", 128'(in_ready_a[1]), 128'(0));
        for (int c = 0; c < 2; c++) begin
            step(1, a);
            if (a) sent++;
            check("stall_valid", 128'(out_valid_a[1]), 128'(1));
            check("stall_data", out_data_a[1], qe[1][0]);
        end
        out_ready[1] = 1'b1;
        for (int c = 0; c < 20 && (sent < 3 || qe[1].size() != 0); c++) begin
            in_valid[1] = sent < 3;
            step(1, a);
            if (a) sent++;
        end
        in_valid[1] = 1'b0;
        check("release_sent", 128'(sent), 128'(3));
        check("release_drain", 128'(qe[1].size()), 128'(0));

        // reset with two words in flight
        out_ready[1] = 1'b0;
        in_valid[1] = 1'b1;
        for (int c = 0; c < 2; c++) begin
            in_data[1] = 128'(rvec(32));
            step(1, a);
        end
        check("inflight", 128'(qe[1].size()), 128'(2));
        do_reset(1);

        // CNT_W=4 counter wraps after 17 deliveries
        stream(0, 17, 100, 100);
        cur_k = 0;
        check("cnt_wrap", 128'(cnt_a[0]), 128'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
